// File: rtl/oam_dma.sv
// Sprite DMA engine: a CPU write to TRIGGER_ADDR halts the CPU and copies one 256-byte page to OAM_PORT.
// Optional macro OAM_DMA_ODD_ALIGN_EN adds the ALIGN state so every READ lands on an even-parity cycle.
module oam_dma #(
  parameter logic [15:0] OAM_PORT     = 16'h2004,
  parameter logic [15:0] TRIGGER_ADDR = 16'h4014
) (
  input  logic        clk_ph1,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_we,
  input  logic [7:0]  bus_din,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_dout,
  output logic        dma_we,
  output logic        dma_active,
  output logic        cpu_halt
);

  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

  state_t      state;
  logic [7:0]  page;
  logic [7:0]  idx;
  logic [7:0]  latch;
  logic        par;

  // Outputs are registered alongside the state, so each transition also loads the decode of the new state.
  always_ff @(posedge clk_ph1) begin
    par <= ~par;
    if (!rst) begin
      state      <= IDLE;
      page       <= 8'h00;
      idx        <= 8'h00;
      latch      <= 8'h00;
      par        <= 1'b0;
      dma_addr   <= 16'h0000;
      dma_we     <= 1'b0;
      dma_active <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_we && cpu_addr == TRIGGER_ADDR) begin
            page       <= cpu_dout;
            idx        <= 8'h00;
            state      <= HALT;
            dma_active <= 1'b1;
          end
        end
        HALT: begin
`ifdef OAM_DMA_ODD_ALIGN_EN
          if (par) begin
            state    <= READ;
            dma_addr <= {page, idx};
          end else begin
            state    <= ALIGN;
          end
`else
          state    <= READ;
          dma_addr <= {page, idx};
`endif
        end
`ifdef OAM_DMA_ODD_ALIGN_EN
        ALIGN: begin
          state    <= READ;
          dma_addr <= {page, idx};
        end
`endif
        READ: begin
          latch    <= bus_din;
          state    <= WRITE;
          dma_addr <= OAM_PORT;
          dma_we   <= 1'b1;
        end
        WRITE: begin
          idx    <= idx + 8'd1;
          dma_we <= 1'b0;
          if (idx == 8'hFF) begin
            state      <= IDLE;
            dma_addr   <= 16'h0000;
            dma_active <= 1'b0;
          end else begin
            state    <= READ;
            dma_addr <= {page, idx + 8'd1};
          end
        end
        default: begin
          state      <= IDLE;
          dma_addr   <= 16'h0000;
          dma_we     <= 1'b0;
          dma_active <= 1'b0;
        end
      endcase
    end
  end

  assign dma_dout = latch;
  assign cpu_halt = dma_active;

endmodule
